pipe_hazard_ctrl: RTL

- Central pipeline sequencer for the 5-stage MIPS core.
- Drives the write-enable and bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Runs the req/ack handshake to data memory for the access currently held in EX/MEM.
- Detects load-use hazards, applies taken-branch flushes, counts stall cycles, and freezes the core on a memory timeout.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_if.sv | 46 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: types and constants shared by the pipeline hazard controller.
//   state_e   : sequencer state (RUN, WAIT, ERROR)
//   reg_idx_t : 5-bit register-file index
//   REG_ZERO  : index of $zero, which never creates a dependency
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } state_e;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundles the pipeline-register controls and the data
// memory handshake of the hazard controller.
//   slave  : the controller side (hazard inputs, dmem_ack_i in; enables,
//            bubbles, dmem_req_o/dmem_we_o, timeout_o, stall_cnt_o out)
//   master : the datapath / memory side (the reverse directions)
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    pipe_ctrl_pkg::reg_idx_t ifid_rs_i;
    pipe_ctrl_pkg::reg_idx_t ifid_rt_i;
    logic                    idex_memread_i;
    pipe_ctrl_pkg::reg_idx_t idex_rt_i;
    logic                    branch_taken_i;
    logic                    exmem_memread_i;
    logic                    exmem_memwrite_i;
    logic                    dmem_ack_i;

    logic                    pc_we_o;
    logic                    ifid_we_o;
    logic                    ifid_flush_o;
    logic                    idex_we_o;
    logic                    idex_bubble_o;
    logic                    exmem_we_o;
    logic                    memwb_we_o;
    logic                    memwb_bubble_o;
    logic                    dmem_req_o;
    logic                    dmem_we_o;
    logic                    timeout_o;
    logic [CNT_W-1:0]        stall_cnt_o;

    modport slave (
        input  ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i, branch_taken_i,
               exmem_memread_i, exmem_memwrite_i, dmem_ack_i,
        output pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_bubble_o,
               exmem_we_o, memwb_we_o, memwb_bubble_o, dmem_req_o, dmem_we_o,
               timeout_o, stall_cnt_o
    );

    modport master (
        output ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i, branch_taken_i,
               exmem_memread_i, exmem_memwrite_i, dmem_ack_i,
        input  pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_bubble_o,
               exmem_we_o, memwb_we_o, memwb_bubble_o, dmem_req_o, dmem_we_o,
               timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use check between the load in ID/EX and
// the source operands of the instruction in IF/ID.
//   ifid_rs_i, ifid_rt_i : source registers of the IF/ID instruction
//   idex_memread_i       : ID/EX holds a load
//   idex_rt_i            : load destination
//   load_use_stall_o     : IF/ID must wait one cycle for the load data
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  reg_idx_t ifid_rs_i,
    input  reg_idx_t ifid_rt_i,
    input  logic     idex_memread_i,
    input  reg_idx_t idex_rt_i,
    output logic     load_use_stall_o
);

    // A load into $zero produces nothing to wait for.
    assign load_use_stall_o = idex_memread_i && (idex_rt_i != REG_ZERO) &&
                              ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central sequencer of the 5-stage pipeline. Produces the
// write enables and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB, runs the data-memory req/ack handshake for the EX/MEM access,
// counts stall cycles and freezes the core if memory never answers.
//   clk_i, rst_i : clock, synchronous active-low reset
//   ctl          : pipe_hazard_ctrl_if.slave (hazard inputs, dmem handshake,
//                  stage controls, timeout_o, stall_cnt_o)
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | pipeline flowing; a memop without same-cycle ack freezes it
// WAIT  | request outstanding, core frozen until ack or timeout
// ERROR | memory never answered; core frozen until reset
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_hazard_ctrl_if.slave ctl
);

    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic memop;
    logic frozen;
    logic load_use_stall;
    logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble;
    logic exmem_we, memwb_we, memwb_bubble, dmem_req;

    hazard_detect u_hazard_detect (
        .ifid_rs_i        (ctl.ifid_rs_i),
        .ifid_rt_i        (ctl.ifid_rt_i),
        .idex_memread_i   (ctl.idex_memread_i),
        .idex_rt_i        (ctl.idex_rt_i),
        .load_use_stall_o (load_use_stall)
    );

    assign memop = ctl.exmem_memread_i | ctl.exmem_memwrite_i;

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b1;
        memwb_we     = 1'b1;
        memwb_bubble = 1'b0;
        dmem_req     = 1'b0;
        frozen       = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;

        if (!rst_i) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            idex_bubble  = 1'b1;
            exmem_we     = 1'b0;
            memwb_we     = 1'b0;
            memwb_bubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (memop) begin
                        dmem_req = 1'b1;
                        if (!ctl.dmem_ack_i) begin
                            frozen     = 1'b1;
                            state_d    = WAIT;
                            wait_cnt_d = WCNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    dmem_req = 1'b1;
                    if (ctl.dmem_ack_i) begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else begin
                        frozen = 1'b1;
                        if (wait_cnt_q == WCNT_W'(TIMEOUT_CYCLES)) begin
                            state_d = ERROR;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                        end
                    end
                end
                ERROR: begin
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    idex_bubble  = 1'b1;
                    exmem_we     = 1'b0;
                    memwb_we     = 1'b0;
                    memwb_bubble = 1'b1;
                end
                default: state_d = RUN;
            endcase

            // MEM/WB keeps clocking during a freeze so that WB retires a
            // bubble instead of repeating the instruction stuck in MEM.
            if (frozen) begin
                pc_we        = 1'b0;
                ifid_we      = 1'b0;
                idex_we      = 1'b0;
                exmem_we     = 1'b0;
                memwb_we     = 1'b1;
                memwb_bubble = 1'b1;
            end else if (state_q != ERROR) begin
                if (load_use_stall) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (ctl.branch_taken_i) begin
                    ifid_flush = 1'b1;
                end
            end
        end
    end

    always_comb begin
        timeout_d   = timeout_q | (state_d == ERROR);
        stall_cnt_d = stall_cnt_q;
        if (!pc_we && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctl.pc_we_o        = pc_we;
    assign ctl.ifid_we_o      = ifid_we;
    assign ctl.ifid_flush_o   = ifid_flush;
    assign ctl.idex_we_o      = idex_we;
    assign ctl.idex_bubble_o  = idex_bubble;
    assign ctl.exmem_we_o     = exmem_we;
    assign ctl.memwb_we_o     = memwb_we;
    assign ctl.memwb_bubble_o = memwb_bubble;
    assign ctl.dmem_req_o     = dmem_req;
    assign ctl.dmem_we_o      = dmem_req & ctl.exmem_memwrite_i;
    assign ctl.timeout_o      = timeout_q;
    assign ctl.stall_cnt_o    = stall_cnt_q;

endmodule
